// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : DLX instruction-fetch stage with the IF/ID pipeline register.
//            Holds the fetch PC, drives the instruction-memory request and
//            captures the returned word (or a NOP bubble) into IF/ID together
//            with pc+4 and the should_be_killed flag seen by decode.
// Ports    :
//   clk                   in   rising-edge clock
//   reset                 in   asynchronous active-high reset
//   imem_addr      [31:0] out  fetch address (combinationally = pc)
//   imem_req              out  fetch request (high unless reset or halt)
//   imem_rdata     [0:31] in   instruction word, bit 0 = opcode MSB
//   imem_ready            in   imem_rdata valid for imem_addr this cycle
//   branch_taken          in   decode redirect
//   branch_target  [31:0] in   decode redirect target (used unaligned as-is)
//   stall                 in   decode stall: re-fetch current PC
//   kill_next_instruction in   decode kill for the word captured this cycle
//   halt                  in   freeze PC and IF/ID
//   pc             [31:0] out  current fetch PC
//   id_instr       [0:31] out  IF/ID instruction
//   id_pc_plus_four[31:0] out  IF/ID fetch address + 4
//   id_kill               out  IF/ID should_be_killed
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [0:31] imem_rdata,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        kill_next_instruction,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [0:31] id_instr,
  output logic [31:0] id_pc_plus_four,
  output logic        id_kill
);

  logic [31:0] pc_q, pc_d;
  logic [0:31] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus_four_q, id_pc_plus_four_d;
  logic        id_kill_q, id_kill_d;
  logic [31:0] pc_plus_four;

  // 32-bit modulo increment; 0xFFFF_FFFC wraps to 0.
  assign pc_plus_four = pc_q + 32'd4;

  always_comb begin
    pc_d              = pc_q;
    id_instr_d        = id_instr_q;
    id_pc_plus_four_d = id_pc_plus_four_q;
    id_kill_d         = id_kill_q;

    if (!halt) begin
      // IF/ID: a memory miss becomes a killed NOP bubble, which also swallows
      // any kill request raised in the same cycle.
      id_pc_plus_four_d = pc_plus_four;
      if (imem_ready) begin
        id_instr_d = imem_rdata;
        id_kill_d  = kill_next_instruction;
      end else begin
        id_instr_d = NOP_INSTR;
        id_kill_d  = 1'b1;
      end

      // PC: redirect beats stall, stall beats advance; a miss simply waits.
      if (branch_taken) begin
        pc_d = branch_target;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (imem_ready) begin
        pc_d = pc_plus_four;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q              <= RESET_PC;
      id_instr_q        <= NOP_INSTR;
      id_pc_plus_four_q <= RESET_PC;
      id_kill_q         <= 1'b1;
    end else begin
      pc_q              <= pc_d;
      id_instr_q        <= id_instr_d;
      id_pc_plus_four_q <= id_pc_plus_four_d;
      id_kill_q         <= id_kill_d;
    end
  end

  assign imem_addr       = pc_q;
  assign imem_req        = ~reset & ~halt;
  assign pc              = pc_q;
  assign id_instr        = id_instr_q;
  assign id_pc_plus_four = id_pc_plus_four_q;
  assign id_kill         = id_kill_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. An instruction memory whose
//            word at address A is {16'hC0DE, A[15:0]} feeds the DUT; a
//            transaction-level model of the fetch rules is compared against
//            the DUT on every falling edge, and directed scenarios pin the
//            model with hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0015;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [0:31] imem_rdata;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        kill_next_instruction;
  logic        halt;
  logic [31:0] pc;
  logic [0:31] id_instr;
  logic [31:0] id_pc_plus_four;
  logic        id_kill;

  int tests  = 0;
  int failed = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(C_RESET_PC), .NOP_INSTR(C_NOP)) dut (
    .clk                  (clk),
    .reset                (reset),
    .imem_addr            (imem_addr),
    .imem_req             (imem_req),
    .imem_rdata           (imem_rdata),
    .imem_ready           (imem_ready),
    .branch_taken         (branch_taken),
    .branch_target        (branch_target),
    .stall                (stall),
    .kill_next_instruction(kill_next_instruction),
    .halt                 (halt),
    .pc                   (pc),
    .id_instr             (id_instr),
    .id_pc_plus_four      (id_pc_plus_four),
    .id_kill              (id_kill)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_ppf;
  logic        m_kill;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= C_RESET_PC;
      m_instr <= C_NOP;
      m_ppf   <= C_RESET_PC;
      m_kill  <= 1'b1;
    end else if (!halt) begin
      m_instr <= imem_ready ? mem_word(m_pc) : C_NOP;
      m_ppf   <= m_pc + 32'd4;
      m_kill  <= imem_ready ? kill_next_instruction : 1'b1;
      if (branch_taken)    m_pc <= branch_target;
      else if (stall)      m_pc <= m_pc;
      else if (imem_ready) m_pc <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("pc",        pc,              m_pc);
      chk("imem_addr", imem_addr,       m_pc);
      chk("imem_req",  {31'd0, imem_req}, {31'd0, ~reset & ~halt});
      chk("id_instr",  id_instr,        m_instr);
      chk("id_ppf",    id_pc_plus_four, m_ppf);
      chk("id_kill",   {31'd0, id_kill}, {31'd0, m_kill});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic br, input logic [31:0] tgt, input logic st,
                     input logic kn, input logic rdy, input logic hl);
    branch_taken          = br;
    branch_target         = tgt;
    stall                 = st;
    kill_next_instruction = kn;
    imem_ready            = rdy;
    halt                  = hl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    branch_taken = 1'b0; branch_target = 32'd0; stall = 1'b0;
    kill_next_instruction = 1'b0; imem_ready = 1'b0; halt = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    started = 1'b1;
    chk("rst pc",       pc, 32'h0);
    chk("rst id_instr", id_instr, 32'h0000_0015);
    chk("rst id_kill",  {31'd0, id_kill}, 32'd1);
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;

    // Reach pc=0x40, then reset mid-run.
    cyc(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre pc", pc, 32'h40);
    #1 reset = 1'b1;
    #1;
    chk("async pc",      pc, 32'h0);
    chk("async id_kill", {31'd0, id_kill}, 32'd1);
    chk("async ppf",     id_pc_plus_four, 32'h0);
    @(posedge clk); #2;
    branch_taken = 1'b0; kill_next_instruction = 1'b0; imem_ready = 1'b1;
    reset = 1'b0;

    // Sequential fetch.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seq W0",      id_instr, 32'hC0DE_0000);
    chk("seq ppf",     id_pc_plus_four, 32'h4);
    chk("seq kill",    {31'd0, id_kill}, 32'd0);
    chk("seq pc1",     pc, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seq pc2",     pc, 32'h8);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seq pc3",     pc, 32'hC);
    chk("seq W2",      id_instr, 32'hC0DE_0008);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seq pc4",     pc, 32'h10);

    // Branch at 0x10.
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("br pc",       pc, 32'h100);
    chk("br slot",     id_instr, 32'hC0DE_0010);
    chk("br kill",     {31'd0, id_kill}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("br tgt word", id_instr, 32'hC0DE_0100);
    chk("br tgt kill", {31'd0, id_kill}, 32'd0);
    chk("br pc+4",     pc, 32'h104);

    // Load stall at 0x20.
    cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("stall word",  id_instr, 32'hC0DE_0020);
    chk("stall kill",  {31'd0, id_kill}, 32'd1);
    chk("stall pc",    pc, 32'h20);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("refetch word", id_instr, 32'hC0DE_0020);
    chk("refetch kill", {31'd0, id_kill}, 32'd0);
    chk("refetch pc",   pc, 32'h24);

    // Memory wait at 0x30; a kill raised during the miss is not deferred.
    cyc(1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, (i == 1), 1'b0, 1'b0);
      chk("wait pc",    pc, 32'h30);
      chk("wait instr", id_instr, 32'h0000_0015);
      chk("wait kill",  {31'd0, id_kill}, 32'd1);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ready word", id_instr, 32'hC0DE_0030);
    chk("ready kill", {31'd0, id_kill}, 32'd0);
    chk("ready pc",   pc, 32'h34);

    // Branch during a miss, with stall also asserted.
    cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("brmiss pc",    pc, 32'h200);
    chk("brmiss instr", id_instr, 32'h0000_0015);
    chk("brmiss kill",  {31'd0, id_kill}, 32'd1);
    chk("brmiss ppf",   id_pc_plus_four, 32'h38);

    // Halt for two cycles while a branch pulses.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b1);
    chk("halt pc",    pc, 32'h204);
    chk("halt instr", id_instr, 32'hC0DE_0200);
    chk("halt ppf",   id_pc_plus_four, 32'h204);
    chk("halt kill",  {31'd0, id_kill}, 32'd0);
    chk("halt req",   {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("unhalt pc",  pc, 32'h208);

    // Unaligned target is taken as-is.
    cyc(1'b1, 32'h103, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("unal pc", pc, 32'h103);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("unal ppf", id_pc_plus_four, 32'h107);

    // Wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap ppf",   id_pc_plus_four, 32'h0);
    chk("wrap pc",    pc, 32'h0);
    chk("wrap instr", id_instr, 32'hC0DE_FFFC);
    chk("wrap kill",  {31'd0, id_kill}, 32'd0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
